// File: rtl/pixel_stream_buf_pkg.sv
// Purpose: shared types and constants for the pixel stream buffer.
// Latency: n/a (types only).
// Backpressure: n/a.
// Contents: FSM state enum, 51-bit FIFO entry layout, default image size,
//           counter-width helper.
package pixel_stream_buf_pkg;

  localparam int DEFAULT_WIDTH  = 768;
  localparam int DEFAULT_HEIGHT = 512;

  localparam int PIX_W   = 48;         // two RGB888 pixels per beat
  localparam int ENTRY_W = PIX_W + 3;  // data + sof/eol/eof tags

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    FLUSH,
    DONE
  } state_t;

  // Tags sit above the pixel data; data keeps BMP byte order (B0 in [7:0]).
  typedef struct packed {
    logic             sof;
    logic             eol;
    logic             eof;
    logic [PIX_W-1:0] data;
  } entry_t;

  // Bits needed to count 0..range-1; never less than one bit.
  function automatic int cnt_w(input int range);
    return (range > 1) ? $clog2(range) : 1;
  endfunction

endpackage

// File: rtl/pixel_stream_buf_if.sv
// Purpose: pixel input beat plus tagged output stream of the pixel buffer.
// Latency: n/a (wiring only).
// Backpressure: out_ready stalls the output side; the input side has none.
// Ports: data_write + DATA_{R,G,B}{0,1} in; out_valid/out_ready/out_data,
//        out_sof/out_eol/out_eof, overflow, frame_done out (slave = buffer).
interface pixel_stream_buf_if;
  import pixel_stream_buf_pkg::*;

  logic             data_write;
  logic [7:0]       DATA_R0;
  logic [7:0]       DATA_G0;
  logic [7:0]       DATA_B0;
  logic [7:0]       DATA_R1;
  logic [7:0]       DATA_G1;
  logic [7:0]       DATA_B1;
  logic             out_valid;
  logic             out_ready;
  logic [PIX_W-1:0] out_data;
  logic             out_sof;
  logic             out_eol;
  logic             out_eof;
  logic             overflow;
  logic             frame_done;

  modport master (
    output data_write, DATA_R0, DATA_G0, DATA_B0, DATA_R1, DATA_G1, DATA_B1,
    output out_ready,
    input  out_valid, out_data, out_sof, out_eol, out_eof, overflow, frame_done
  );

  modport slave (
    input  data_write, DATA_R0, DATA_G0, DATA_B0, DATA_R1, DATA_G1, DATA_B1,
    input  out_ready,
    output out_valid, out_data, out_sof, out_eol, out_eof, overflow, frame_done
  );

endinterface

// File: rtl/pixel_stream_buf_sync_fifo.sv
// Purpose: generic synchronous FIFO, register-array storage.
// Latency: write on cycle N is visible at rdata/!empty on cycle N+1.
// Backpressure: full blocks push unless a pop happens in the same cycle.
// Ports: HCLK, HRESETn; push/wdata in; pop in; rdata (head), full, empty out.
module sync_fifo #(
  parameter int WIDTH = 51,
  parameter int DEPTH = 16
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop && !empty;
  // When full, the slot being written is the one popped this cycle; the
  // read below sees the old contents because the write lands at the edge.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge HCLK) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pixel_stream_buf.sv
// Purpose: buffers one frame of two-pixel beats and tags sof/eol/eof.
// Latency: beat written on cycle N appears at out_valid on cycle N+1.
// Backpressure: out_ready stalls output; input beats that cannot fit are dropped (sticky overflow).
// Ports: HCLK, HRESETn (async, active-low); bus = pixel_stream_buf_if.slave
//        carrying data_write/DATA_*, out_valid/out_ready/out_data, sidebands,
//        overflow and frame_done.
module pixel_stream_buf
  import pixel_stream_buf_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int HEIGHT = DEFAULT_HEIGHT,
  parameter int DEPTH  = 16
) (
  input logic               HCLK,
  input logic               HRESETn,
  pixel_stream_buf_if.slave bus
);

  localparam int BEATS = WIDTH * HEIGHT / 2;
  localparam int COL_W = cnt_w(WIDTH);
  localparam int ROW_W = cnt_w(HEIGHT);
  localparam int CNT_W = cnt_w(BEATS);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH - 2);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BEATS - 1);

  state_t             state_q;
  state_t             state_d;
  logic [COL_W-1:0]   in_col;
  logic [ROW_W-1:0]   in_row;
  logic [CNT_W-1:0]   in_cnt;
  logic [COL_W-1:0]   cur_col;
  logic [ROW_W-1:0]   cur_row;
  logic [CNT_W-1:0]   cur_cnt;
  logic               overflow_q;
  logic               take;
  logic               push;
  logic               pop;
  logic               drop;
  logic               last_beat;
  logic               fifo_full;
  logic               fifo_empty;
  entry_t             wr_entry;
  entry_t             rd_entry;
  logic [ENTRY_W-1:0] rd_raw;

  // A write in IDLE starts a fresh frame, so it is tagged from zeroed counters.
  assign cur_col = (state_q == IDLE) ? '0 : in_col;
  assign cur_row = (state_q == IDLE) ? '0 : in_row;
  assign cur_cnt = (state_q == IDLE) ? '0 : in_cnt;

  assign take      = bus.data_write && ((state_q == IDLE) || (state_q == STREAM));
  assign pop       = !fifo_empty && bus.out_ready;
  assign push      = take && (!fifo_full || pop);
  assign drop      = bus.data_write && !push;
  assign last_beat = (cur_cnt == CNT_LAST);

  always_comb begin
    wr_entry      = '0;
    wr_entry.sof  = (cur_cnt == '0);
    wr_entry.eol  = (cur_col == COL_LAST);
    wr_entry.eof  = last_beat;
    wr_entry.data = {bus.DATA_R1, bus.DATA_G1, bus.DATA_B1,
                     bus.DATA_R0, bus.DATA_G0, bus.DATA_B0};
  end

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .push    (push),
    .wdata   (wr_entry),
    .pop     (pop),
    .rdata   (rd_raw),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign rd_entry = entry_t'(rd_raw);

  // Outputs are gated by !empty so stale storage never leaks out.
  assign bus.out_valid  = !fifo_empty;
  assign bus.out_data   = fifo_empty ? '0 : rd_entry.data;
  assign bus.out_sof    = !fifo_empty && rd_entry.sof;
  assign bus.out_eol    = !fifo_empty && rd_entry.eol;
  assign bus.out_eof    = !fifo_empty && rd_entry.eof;
  assign bus.overflow   = overflow_q;
  assign bus.frame_done = (state_q == DONE);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (bus.data_write) state_d = last_beat ? FLUSH : STREAM;
      STREAM: if (bus.data_write && last_beat) state_d = FLUSH;
      // Empty in FLUSH only happens if the eof beat itself was dropped;
      // finishing then keeps the block from waiting forever for it.
      FLUSH:  if ((pop && rd_entry.eof) || fifo_empty) state_d = DONE;
      DONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Counters advance on every accepted-or-dropped beat of the frame so the
  // eol/eof positions stay aligned with the image even after a drop.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      in_col <= '0;
      in_row <= '0;
      in_cnt <= '0;
    end else if (take) begin
      in_cnt <= cur_cnt + CNT_W'(1);
      if (cur_col == COL_LAST) begin
        in_col <= '0;
        in_row <= cur_row + ROW_W'(1);
      end else begin
        in_col <= cur_col + COL_W'(2);
        in_row <= cur_row;
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      overflow_q <= 1'b0;
    end else if (drop) begin
      overflow_q <= 1'b1;
    end else if ((state_q == IDLE) && bus.data_write) begin
      overflow_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pixel_stream_buf.sv
// Purpose: directed bench for pixel_stream_buf with two small configurations.
// dut_a: 4x2 image (4 beats), DEPTH 4. dut_b: 4x4 image (8 beats), DEPTH 4.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_pixel_stream_buf;
  import pixel_stream_buf_pkg::*;

  logic HCLK = 1'b0;
  logic HRESETn = 1'b0;
  always #5 HCLK = ~HCLK;

  pixel_stream_buf_if ia();
  pixel_stream_buf_if ib();

  pixel_stream_buf #(.WIDTH(4), .HEIGHT(2), .DEPTH(4)) dut_a (
    .HCLK(HCLK), .HRESETn(HRESETn), .bus(ia)
  );
  pixel_stream_buf #(.WIDTH(4), .HEIGHT(4), .DEPTH(4)) dut_b (
    .HCLK(HCLK), .HRESETn(HRESETn), .bus(ib)
  );

  logic [7:0] r0, g0, b0, r1, g1, b1;
  logic       dw [2];
  logic       rdy [2];

  assign ia.data_write = dw[0];
  assign ib.data_write = dw[1];
  assign ia.out_ready  = rdy[0];
  assign ib.out_ready  = rdy[1];
  assign ia.DATA_R0 = r0; assign ia.DATA_G0 = g0; assign ia.DATA_B0 = b0;
  assign ia.DATA_R1 = r1; assign ia.DATA_G1 = g1; assign ia.DATA_B1 = b1;
  assign ib.DATA_R0 = r0; assign ib.DATA_G0 = g0; assign ib.DATA_B0 = b0;
  assign ib.DATA_R1 = r1; assign ib.DATA_G1 = g1; assign ib.DATA_B1 = b1;

  logic        o_vld [2], o_sof [2], o_eol [2], o_eof [2], o_ovf [2], o_done [2];
  logic [47:0] o_dat [2];

  assign o_vld[0] = ia.out_valid; assign o_vld[1] = ib.out_valid;
  assign o_dat[0] = ia.out_data;  assign o_dat[1] = ib.out_data;
  assign o_sof[0] = ia.out_sof;   assign o_sof[1] = ib.out_sof;
  assign o_eol[0] = ia.out_eol;   assign o_eol[1] = ib.out_eol;
  assign o_eof[0] = ia.out_eof;   assign o_eof[1] = ib.out_eof;
  assign o_ovf[0] = ia.overflow;  assign o_ovf[1] = ib.overflow;
  assign o_done[0] = ia.frame_done; assign o_done[1] = ib.frame_done;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Beat k carries components 0x11+k .. 0x66+k.
  task automatic set_beat(input int k);
    r0 = 8'h11 + 8'(k); g0 = 8'h22 + 8'(k); b0 = 8'h33 + 8'(k);
    r1 = 8'h44 + 8'(k); g1 = 8'h55 + 8'(k); b1 = 8'h66 + 8'(k);
  endtask

  function automatic logic [47:0] beat_dat(input int k);
    return {8'h44 + 8'(k), 8'h55 + 8'(k), 8'h66 + 8'(k),
            8'h11 + 8'(k), 8'h22 + 8'(k), 8'h33 + 8'(k)};
  endfunction

  // Drives beats 0..nbeats-1 on cycles 0..nbeats-1, raises out_ready from
  // cycle ready_at, and checks every accepted beat against the expected order
  // (beat drop_idx never appears; beats past the frame length are dropped).
  // Both DUTs have WIDTH=4, so eol is on odd beats.
  task automatic run_frame(input int d, input string tag, input int nbeats,
                           input int ready_at, input int drop_idx, input int frame_len,
                           input int exp_done, input logic exp_ovf);
    int exp_q[$];
    int first_vld = -1;
    int done_cyc = -1;
    int done_cnt = 0;
    int extra = 0;
    int k;
    for (int i = 0; i < nbeats && i < frame_len; i++)
      if (i != drop_idx) exp_q.push_back(i);
    for (int c = 0; c < 18; c++) begin
      @(negedge HCLK);
      dw[d]  = (c < nbeats);
      rdy[d] = (c >= ready_at);
      set_beat(c);
      if (o_vld[d] && first_vld < 0) first_vld = c;
      if (o_done[d]) begin
        done_cnt++;
        done_cyc = c;
      end
      if (o_vld[d] && rdy[d]) begin
        if (exp_q.size() == 0) begin
          extra++;
        end else begin
          k = exp_q.pop_front();
          check_val($sformatf("%s_dat%0d", tag, k), o_dat[d], beat_dat(k));
          if (k == 0) check_val({tag, "_bmp_order"}, o_dat[d], 48'h445566112233);
          check_val($sformatf("%s_sof%0d", tag, k), o_sof[d], k == 0);
          check_val($sformatf("%s_eol%0d", tag, k), o_eol[d], (k % 2) == 1);
          check_val($sformatf("%s_eof%0d", tag, k), o_eof[d], k == frame_len - 1);
        end
      end
    end
    dw[d]  = 1'b0;
    rdy[d] = 1'b0;
    check_val({tag, "_missing_beats"}, exp_q.size(), 0);
    check_val({tag, "_extra_beats"}, extra, 0);
    check_val({tag, "_first_valid_cycle"}, first_vld, 1);
    check_val({tag, "_frame_done_count"}, done_cnt, 1);
    check_val({tag, "_frame_done_cycle"}, done_cyc, exp_done);
    check_val({tag, "_overflow"}, o_ovf[d], exp_ovf);
  endtask

  initial begin
    dw[0] = 1'b0; dw[1] = 1'b0; rdy[0] = 1'b0; rdy[1] = 1'b0;
    set_beat(0);
    #12;
    for (int d = 0; d < 2; d++) begin
      check_val($sformatf("rst%0d_valid", d), o_vld[d], 0);
      check_val($sformatf("rst%0d_data", d), o_dat[d], 0);
      check_val($sformatf("rst%0d_sof", d), o_sof[d], 0);
      check_val($sformatf("rst%0d_eol", d), o_eol[d], 0);
      check_val($sformatf("rst%0d_eof", d), o_eof[d], 0);
      check_val($sformatf("rst%0d_overflow", d), o_ovf[d], 0);
      check_val($sformatf("rst%0d_frame_done", d), o_done[d], 0);
    end
    @(negedge HCLK);
    HRESETn = 1'b1;

    // 4 beats streamed straight through: valid cycles 1-4, frame_done cycle 5.
    run_frame(0, "basic", 4, 0, -1, 4, 5, 1'b0);
    // Frame buffered with out_ready low, extra beat arrives in FLUSH.
    run_frame(0, "flush_drop", 5, 5, -1, 4, 9, 1'b1);
    // Full FIFO with a pop in the same cycle as the write: nothing lost.
    run_frame(1, "full_pushpop", 8, 4, -1, 8, 12, 1'b0);
    // Full FIFO, no pop: beat 4 dropped, later tags still line up.
    run_frame(1, "full_drop", 8, 5, 4, 8, 12, 1'b1);

    // Reset in the middle of a frame with two beats buffered.
    @(negedge HCLK);
    dw[0] = 1'b1; rdy[0] = 1'b0; set_beat(0);
    @(negedge HCLK);
    set_beat(1);
    @(negedge HCLK);
    dw[0] = 1'b0;
    check_val("midrst_pre_valid", o_vld[0], 1);
    check_val("midrst_pre_overflow_b", o_ovf[1], 1);
    #2 HRESETn = 1'b0;
    #1;
    check_val("midrst_valid", o_vld[0], 0);
    check_val("midrst_data", o_dat[0], 0);
    check_val("midrst_sof", o_sof[0], 0);
    check_val("midrst_frame_done", o_done[0], 0);
    check_val("midrst_overflow_b", o_ovf[1], 0);
    @(negedge HCLK);
    HRESETn = 1'b1;
    run_frame(0, "after_rst", 4, 0, -1, 4, 5, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pixel_stream_buf.md
PIXEL_STREAM_BUF -- requirements
Module: pixel_stream_buf

Interface
REQ-001 SHALL have parameter WIDTH, default 768, meaning image width in pixels (even).
REQ-002 SHALL have parameter HEIGHT, default 512, meaning image height in rows.
REQ-003 SHALL have parameter DEPTH, default 16, meaning FIFO entries (power of 2, >=4).
REQ-004 SHALL have port HCLK  input  1  clock; all state changes on its rising edge.
REQ-005 SHALL have port HRESETn  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port data_write  input  1  input beat valid; no backpressure upstream.
REQ-007 SHALL have ports DATA_R0, DATA_G0, DATA_B0, DATA_R1, DATA_G1, DATA_B1  input  8 each  even/odd pixel components.
REQ-008 SHALL have port out_valid  output  1  output beat valid.
REQ-009 SHALL have port out_ready  input  1  downstream accepts beat.
REQ-010 SHALL have port out_data  output  48  {R1,G1,B1,R0,G0,B0}; B0 in [7:0], which is BMP byte order.
REQ-011 SHALL have ports out_sof, out_eol, out_eof  output  1 each  first beat of frame, last beat of row, last beat of frame.
REQ-012 SHALL have port overflow  output  1  sticky; at least one input beat dropped.
REQ-013 SHALL have port frame_done  output  1  one-cycle pulse after the final beat is accepted.

Function
REQ-014 A beat SHALL be accepted on out_valid && out_ready; out_data and sidebands SHALL hold stable while out_valid && !out_ready.
REQ-015 An input beat on cycle N into an empty FIFO SHALL give out_valid=1 on cycle N+1 (registered, no combinational path from data_write to out_valid).
REQ-016 The FSM SHALL have states IDLE, STREAM, FLUSH, DONE.
REQ-017 In IDLE, data_write SHALL push the beat and move to STREAM; it SHALL also clear in_col, in_row, in_cnt, and clear overflow.
REQ-018 STREAM SHALL go to FLUSH on the cycle the beat with in_cnt == WIDTH*HEIGHT/2-1 is pushed.
REQ-019 FLUSH SHALL go to DONE on the cycle the out_eof beat is accepted.
REQ-020 DONE SHALL last one cycle, asserting frame_done, then go to IDLE.
REQ-021 Per pushed beat, in_col SHALL advance by 2 and wrap to 0 after WIDTH-2; in_row SHALL increment on that wrap.
REQ-022 Sideband tags SHALL be computed at push and stored with the data as 51-bit FIFO entries: sof = (in_cnt==0), eol = (in_col==WIDTH-2), eof = (in_cnt==last).
REQ-023 A push SHALL succeed if the FIFO is not full, or if it is full and a pop occurs in the same cycle.
REQ-024 A push SHALL otherwise be dropped and set overflow; dropped beats still advance the counters, so eol/eof alignment holds.
REQ-025 data_write in FLUSH or DONE SHALL be dropped and set overflow.
REQ-026 Simultaneous push and pop SHALL leave occupancy unchanged; pointers SHALL wrap modulo DEPTH.
REQ-027 Counter widths SHALL be clog2 of the range (in_cnt 18 bits at defaults); there SHALL be no arithmetic on pixel data.

Reset
REQ-028 On HRESETn low, asynchronously: state=IDLE; FIFO empty; counters 0; out_valid, out_sof, out_eol, out_eof, overflow, frame_done = 0; out_data = 0.
REQ-029 Reset mid-frame SHALL discard buffered beats; the next data_write after release starts a new frame with sof.

Structure
REQ-030 The shared package SHALL hold the FSM state enumeration, the 51-bit FIFO entry layout (data + 3 tag bits), and the default WIDTH/HEIGHT constants.
REQ-031 Storage SHALL be one sub-module, sync_fifo (parameterised width/depth, full/empty, async active-low reset); FSM, counters and tagging SHALL live in pixel_stream_buf.

Verification
REQ-032 With WIDTH=4, HEIGHT=2 and out_ready=1, drive 4 consecutive beats -> out_valid cycles 1-4; sof on beat 0, eol on beats 1 and 3, eof on beat 3; frame_done on cycle 5.
REQ-033 Drive R0=0x11, G0=0x22, B0=0x33, R1=0x44, G1=0x55, B1=0x66 -> out_data = 0x445566112233.
REQ-034 With DEPTH=4, out_ready=0 and 5 beats -> first 4 beats held in order, overflow=1; after out_ready=1, beat 4 is never emitted and eof is still set correctly.
REQ-035 With a full FIFO and out_ready=1 in the same cycle as data_write -> push accepted, overflow stays 0.
REQ-036 Assert HRESETn low after 2 of 4 beats -> all outputs 0 immediately; a new 4-beat frame then completes with sof/eof correct.
REQ-037 data_write asserted during FLUSH -> beat dropped, overflow=1, frame_done still pulses once.
